// File: rtl/exe_pkg.sv
// Shared encodings for the execute stage: ALU commands, branch types and mul/div FSM state.
// Also holds the mul/div operation select used between exe_stage and iter_muldiv.
package exe_pkg;

    localparam logic [3:0] CmdAdd = 4'd0;
    localparam logic [3:0] CmdSub = 4'd1;
    localparam logic [3:0] CmdAnd = 4'd2;
    localparam logic [3:0] CmdOr  = 4'd3;
    localparam logic [3:0] CmdNor = 4'd4;
    localparam logic [3:0] CmdXor = 4'd5;
    localparam logic [3:0] CmdSll = 4'd6;
    localparam logic [3:0] CmdSra = 4'd7;
    localparam logic [3:0] CmdSrl = 4'd8;
    localparam logic [3:0] CmdMul = 4'd9;
    localparam logic [3:0] CmdDiv = 4'd10;

    localparam logic [1:0] BrNone = 2'd0;
    localparam logic [1:0] BrBez  = 2'd1;
    localparam logic [1:0] BrBne  = 2'd2;
    localparam logic [1:0] BrJmp  = 2'd3;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StBusy = 2'd1,
        StDone = 2'd2
    } muldiv_state_e;

    typedef enum logic {
        OpMul = 1'b0,
        OpDiv = 1'b1
    } muldiv_op_e;

endpackage

// File: rtl/iter_muldiv.sv
// Iterative shift-add multiplier and restoring divider, one bit per cycle over DATA_W cycles.
// The divider datapath is only built when EXE_DIV_EN is defined; otherwise DIV starts are ignored.
module iter_muldiv
    import exe_pkg::*;
#(
    parameter int unsigned DATA_W = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              freeze,
    input  logic              start,
    input  muldiv_op_e        op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] result
);

    localparam int unsigned CntW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CntW-1:0] LastCnt = CntW'(DATA_W - 1);

    muldiv_state_e     state_q, state_d;
    logic [CntW-1:0]   count_q, count_d;
    logic [DATA_W-1:0] a_q, a_d;
    logic [DATA_W-1:0] b_q, b_d;
    logic [DATA_W-1:0] acc_q, acc_d;
    logic              start_ok;

`ifdef EXE_DIV_EN
    muldiv_op_e        op_q, op_d;
    logic [DATA_W-1:0] rem_q, rem_d;
    logic [DATA_W:0]   rem_shift;

    assign start_ok = start;
`else
    assign start_ok = start && (op == OpMul);
`endif

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
`ifdef EXE_DIV_EN
        op_d      = op_q;
        rem_d     = rem_q;
        rem_shift = '0;
`endif
        case (state_q)
            StIdle: begin
                if (start_ok) begin
                    a_d     = a;
                    b_d     = b;
                    acc_d   = '0;
                    count_d = '0;
                    state_d = StBusy;
`ifdef EXE_DIV_EN
                    op_d  = op;
                    rem_d = '0;
                    // Divide by zero short-circuits straight to an all-ones quotient.
                    if (op == OpDiv && b == '0) begin
                        a_d     = '1;
                        state_d = StDone;
                    end
`endif
                end
            end
            StBusy: begin
                count_d = count_q + CntW'(1);
                if (count_q == LastCnt) begin
                    state_d = StDone;
                end
`ifdef EXE_DIV_EN
                if (op_q == OpDiv) begin
                    // a_q shifts the dividend out and the quotient bits in.
                    rem_shift = {rem_q, a_q[DATA_W-1]};
                    a_d       = a_q << 1;
                    if (rem_shift >= {1'b0, b_q}) begin
                        rem_shift = rem_shift - {1'b0, b_q};
                        a_d[0]    = 1'b1;
                    end
                    rem_d = rem_shift[DATA_W-1:0];
                end else
`endif
                begin
                    if (b_q[0]) begin
                        acc_d = acc_q + a_q;
                    end
                    a_d = a_q << 1;
                    b_d = b_q >> 1;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= StIdle;
            count_q <= '0;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
`ifdef EXE_DIV_EN
            op_q    <= OpMul;
            rem_q   <= '0;
`endif
        end else if (!freeze) begin
            state_q <= state_d;
            count_q <= count_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
`ifdef EXE_DIV_EN
            op_q    <= op_d;
            rem_q   <= rem_d;
`endif
        end
    end

    // Busy covers the arrival cycle too, so the front end holds before the first edge.
    assign busy = (state_q == StIdle && start_ok) || (state_q == StBusy);
    assign done = (state_q == StDone);

`ifdef EXE_DIV_EN
    assign result = (op_q == OpDiv) ? a_q : acc_q;
`else
    assign result = acc_q;
`endif

endmodule

// File: rtl/exe_stage.sv
// Execute stage: single-cycle ALU, branch resolution, iterative mul/div and the EXE/MEM register.
// DIV support depends on EXE_DIV_EN (see iter_muldiv); without it DIV yields 0 with no stall.
module exe_stage
    import exe_pkg::*;
#(
    parameter int unsigned len    = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              valid,
    input  logic [len-1:0]    pc,
    input  logic [3:0]        exe_cmd,
    input  logic [1:0]        branch_type,
    input  logic [DATA_W-1:0] alu_inp1,
    input  logic [DATA_W-1:0] alu_inp2,
    input  logic [DATA_W-1:0] reg2,
    input  logic [4:0]        dest,
    input  logic              wb_en,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic              freeze,
    output logic              stall,
    output logic              branch_taken,
    output logic [len-1:0]    branch_addr,
    output logic [DATA_W-1:0] alu_result_out,
    output logic [DATA_W-1:0] reg2_out,
    output logic [4:0]        dest_out,
    output logic              wb_en_out,
    output logic              mem_read_out,
    output logic              mem_write_out,
    output logic [len-1:0]    pc_out
);

    logic [DATA_W-1:0] alu_result;
    logic [4:0]        shamt;
    logic              branch_cond;

    logic              md_start;
    muldiv_op_e        md_op;
    logic              md_busy;
    logic              md_done;
    logic [DATA_W-1:0] md_result;

    logic [DATA_W-1:0] alu_result_q, alu_result_d;
    logic [DATA_W-1:0] reg2_q, reg2_d;
    logic [4:0]        dest_q, dest_d;
    logic              wb_en_q, wb_en_d;
    logic              mem_read_q, mem_read_d;
    logic              mem_write_q, mem_write_d;
    logic [len-1:0]    pc_q, pc_d;

    assign shamt = alu_inp2[4:0];

    always_comb begin
        alu_result = '0;
        case (exe_cmd)
            CmdAdd:  alu_result = alu_inp1 + alu_inp2;
            CmdSub:  alu_result = alu_inp1 - alu_inp2;
            CmdAnd:  alu_result = alu_inp1 & alu_inp2;
            CmdOr:   alu_result = alu_inp1 | alu_inp2;
            CmdNor:  alu_result = ~(alu_inp1 | alu_inp2);
            CmdXor:  alu_result = alu_inp1 ^ alu_inp2;
            CmdSll:  alu_result = alu_inp1 << shamt;
            CmdSra:  alu_result = $signed(alu_inp1) >>> shamt;
            CmdSrl:  alu_result = alu_inp1 >> shamt;
            default: alu_result = '0;
        endcase
    end

    always_comb begin
        branch_cond = 1'b0;
        case (branch_type)
            BrBez:   branch_cond = (alu_inp1 == '0);
            BrBne:   branch_cond = (alu_inp1 != reg2);
            BrJmp:   branch_cond = 1'b1;
            default: branch_cond = 1'b0;
        endcase
    end

    assign branch_taken = valid && !reset && branch_cond;
    assign branch_addr  = pc + len'({alu_inp2, 2'b00});

    assign md_start = valid && (exe_cmd == CmdMul || exe_cmd == CmdDiv);
    assign md_op    = (exe_cmd == CmdDiv) ? OpDiv : OpMul;

    iter_muldiv #(
        .DATA_W (DATA_W)
    ) u_iter_muldiv (
        .clock  (clock),
        .reset  (reset),
        .freeze (freeze),
        .start  (md_start),
        .op     (md_op),
        .a      (alu_inp1),
        .b      (alu_inp2),
        .busy   (md_busy),
        .done   (md_done),
        .result (md_result)
    );

    assign stall = md_busy && !reset;

    always_comb begin
        alu_result_d = alu_result_q;
        reg2_d       = reg2_q;
        dest_d       = dest_q;
        wb_en_d      = wb_en_q;
        mem_read_d   = mem_read_q;
        mem_write_d  = mem_write_q;
        pc_d         = pc_q;
        if (freeze) begin
            // MEM stall: hold everything.
        end else if (stall) begin
            wb_en_d     = 1'b0;
            mem_read_d  = 1'b0;
            mem_write_d = 1'b0;
        end else begin
            alu_result_d = md_done ? md_result : alu_result;
            reg2_d       = reg2;
            dest_d       = dest;
            wb_en_d      = valid && wb_en;
            mem_read_d   = valid && mem_read;
            mem_write_d  = valid && mem_write;
            pc_d         = pc;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            alu_result_q <= '0;
            reg2_q       <= '0;
            dest_q       <= '0;
            wb_en_q      <= 1'b0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            pc_q         <= '0;
        end else begin
            alu_result_q <= alu_result_d;
            reg2_q       <= reg2_d;
            dest_q       <= dest_d;
            wb_en_q      <= wb_en_d;
            mem_read_q   <= mem_read_d;
            mem_write_q  <= mem_write_d;
            pc_q         <= pc_d;
        end
    end

    assign alu_result_out = alu_result_q;
    assign reg2_out       = reg2_q;
    assign dest_out       = dest_q;
    assign wb_en_out      = wb_en_q;
    assign mem_read_out   = mem_read_q;
    assign mem_write_out  = mem_write_q;
    assign pc_out         = pc_q;

endmodule
